// File: rtl/bus_slot_scheduler.sv
// Shared-bus slot scheduler: a fixed 16-cycle frame carved into Pi (c0-3), video (c4-7)
// and CPU (c8-15) slots, with a pending/done handshake that grants the Pi one frame at a time.
module bus_slot_scheduler #(
    parameter bit VIDEO_EN = 1'b1
) (
    input  logic       clk16,
    input  logic       res_b,
    input  logic       pi_pending,
    input  logic       pi_rw_b,
    input  logic [7:0] bus_data_i,
    output logic       pi_done,
    output logic [7:0] pi_rd_data,
    output logic       pi_select,
    output logic       pi_read,
    output logic       pi_write,
    output logic       video_select,
    output logic       video_ram_strobe,
    output logic       video_rom_strobe,
    output logic       cpu_select,
    output logic       io_select,
    output logic       phi2,
    output logic       clk8,
    output logic [3:0] slot
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } pi_state_t;

    pi_state_t  state, state_next;
    logic [3:0] c, c_next;
    logic       pend_s1, pend_s2;
    logic       pi_rw_q, rw_next;
    logic [7:0] rd_next;

    // Decoded outputs are computed from the next-cycle counter/state so that the
    // registered outputs line up exactly with the registered c and FSM state.
    logic pi_sel_n, pi_rd_n, pi_wr_n, vid_n, vram_n, vrom_n;
    logic cpu_n, io_n, phi2_n, clk8_n, done_n;

    always_comb begin
        c_next     = c + 4'd1;
        state_next = state;
        rw_next    = pi_rw_q;
        rd_next    = pi_rd_data;
        case (state)
            IDLE: begin
                if (c == 4'd15 && pend_s2) begin
                    state_next = ACCESS;
                    rw_next    = pi_rw_b;
                end
            end
            ACCESS: begin
                if (c == 4'd3) begin
                    state_next = DONE;
                    if (pi_rw_q) rd_next = bus_data_i;
                end
            end
            DONE: begin
                if (!pend_s2) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pi_sel_n = (state_next == ACCESS) && (c_next[3:2] == 2'b00);
        pi_rd_n  = pi_sel_n && rw_next && (c_next == 4'd1 || c_next == 4'd2);
        pi_wr_n  = pi_sel_n && !rw_next && (c_next == 4'd1 || c_next == 4'd2);
        vid_n    = VIDEO_EN && (c_next[3:2] == 2'b01);
        vram_n   = vid_n && !c_next[1];
        vrom_n   = vid_n && c_next[1];
        cpu_n    = c_next[3];
        io_n     = c_next[3] && (c_next != 4'd8);
        phi2_n   = (c_next[3:2] == 2'b11);
        clk8_n   = c_next[0];
        done_n   = (state_next == DONE);
    end

    always_ff @(posedge clk16 or negedge res_b) begin
        if (!res_b) begin
            c                <= 4'd0;
            state            <= IDLE;
            pend_s1          <= 1'b0;
            pend_s2          <= 1'b0;
            pi_rw_q          <= 1'b0;
            pi_rd_data       <= 8'h00;
            pi_done          <= 1'b0;
            pi_select        <= 1'b0;
            pi_read          <= 1'b0;
            pi_write         <= 1'b0;
            video_select     <= 1'b0;
            video_ram_strobe <= 1'b0;
            video_rom_strobe <= 1'b0;
            cpu_select       <= 1'b0;
            io_select        <= 1'b0;
            phi2             <= 1'b0;
            clk8             <= 1'b0;
        end else begin
            c                <= c_next;
            state            <= state_next;
            pend_s1          <= pi_pending;
            pend_s2          <= pend_s1;
            pi_rw_q          <= rw_next;
            pi_rd_data       <= rd_next;
            pi_done          <= done_n;
            pi_select        <= pi_sel_n;
            pi_read          <= pi_rd_n;
            pi_write         <= pi_wr_n;
            video_select     <= vid_n;
            video_ram_strobe <= vram_n;
            video_rom_strobe <= vrom_n;
            cpu_select       <= cpu_n;
            io_select        <= io_n;
            phi2             <= phi2_n;
            clk8             <= clk8_n;
        end
    end

    assign slot = c;

endmodule
